// File: rtl/aer_encoder_sliced_stream.sv
// Sliced AER encoder: one priority-encoding lane per slice, class-rotated lane placement,
// per-lane valid/ready or a merged round-robin serial stream, with run/done control and event count.
module aer_encoder_sliced_stream #(
   parameter int unsigned NUM_SLICE   = 10,
   parameter int unsigned SLICE_DEPTH = 20,
   parameter int unsigned AER_W       = 8,
   parameter int unsigned CLASS_W     = 4,
   parameter int unsigned CNT_W       = $clog2(NUM_SLICE*SLICE_DEPTH+1)
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start_i,
   input  logic                           mode_i,
   input  logic [CLASS_W-1:0]             error_class_i,
   input  logic [NUM_SLICE*SLICE_DEPTH-1:0] hot_vector_i,
   input  logic [NUM_SLICE-1:0]           lane_en_i,
   input  logic [NUM_SLICE-1:0]           lane_ready_i,
   output logic [NUM_SLICE-1:0]           lane_valid_o,
   output logic [NUM_SLICE*AER_W-1:0]     lane_aer_o,
   input  logic                           ser_ready_i,
   output logic                           ser_valid_o,
   output logic [AER_W-1:0]               ser_aer_o,
   output logic                           busy_o,
   output logic                           done_o,
   output logic [CNT_W-1:0]               event_cnt_o
);

   localparam int unsigned NUM_BITS = NUM_SLICE * SLICE_DEPTH;
   localparam int unsigned LANE_W   = (NUM_SLICE > 1) ? $clog2(NUM_SLICE) : 1;
   localparam int unsigned POS_W    = (SLICE_DEPTH > 1) ? $clog2(SLICE_DEPTH) : 1;

   if (AER_W < $clog2(NUM_BITS)) begin : g_aer_w_check
      $error("AER_W too narrow for NUM_SLICE*SLICE_DEPTH addresses");
   end

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t                 r_state, w_state_nxt;
   logic                   w_done_nxt;
   logic                   r_done;
   logic                   r_mode;
   logic [LANE_W-1:0]      r_rot;
   logic [LANE_W-1:0]      r_ptr;
   logic [CNT_W-1:0]       r_cnt;
   logic [SLICE_DEPTH-1:0] r_pend     [NUM_SLICE];
   logic [NUM_SLICE-1:0]   r_head_vld;
   logic [POS_W-1:0]       r_head_pos [NUM_SLICE];

   logic [SLICE_DEPTH-1:0] w_slice_in   [NUM_SLICE];
   logic [AER_W-1:0]       w_head_aer   [NUM_SLICE];
   logic [LANE_W-1:0]      w_lane2slice [NUM_SLICE];
   logic [LANE_W-1:0]      w_slice2lane [NUM_SLICE];
   logic [NUM_SLICE-1:0]   w_elig;
   logic [LANE_W-1:0]      w_grant;
   logic [LANE_W-1:0]      w_ptr_nxt;
   logic [NUM_SLICE-1:0]   w_lane_acc;
   logic [NUM_SLICE-1:0]   w_pop;
   logic [CNT_W-1:0]       w_n_acc;
   logic [CNT_W:0]         w_cnt_sum;

   // Position of the lowest set bit (0 when empty).
   function automatic logic [POS_W-1:0] f_low(input logic [SLICE_DEPTH-1:0] v);
      logic [POS_W-1:0] pos;
      pos = '0;
      for (int i = SLICE_DEPTH - 1; i >= 0; i--) begin
         if (v[i]) pos = POS_W'(i);
      end
      return pos;
   endfunction

   // Bit b belongs to slice b % NUM_SLICE at position b / NUM_SLICE.
   always_comb begin
      w_slice_in = '{default: '0};
      for (int q = 0; q < NUM_SLICE; q++) begin
         for (int p = 0; p < SLICE_DEPTH; p++) begin
            w_slice_in[q][p] = hot_vector_i[p*NUM_SLICE + q];
         end
      end
   end

   // Slice q sits on lane (q + rot) mod NUM_SLICE.
   always_comb begin
      int unsigned v_s, v_l;
      v_s = 0;
      v_l = 0;
      for (int i = 0; i < NUM_SLICE; i++) begin
         v_s = 32'(i) + NUM_SLICE - 32'(r_rot);
         if (v_s >= NUM_SLICE) v_s = v_s - NUM_SLICE;
         v_l = 32'(i) + 32'(r_rot);
         if (v_l >= NUM_SLICE) v_l = v_l - NUM_SLICE;
         w_lane2slice[i] = LANE_W'(v_s);
         w_slice2lane[i] = LANE_W'(v_l);
         w_head_aer[i]   = AER_W'(32'(r_head_pos[i]) * NUM_SLICE + 32'(i));
      end
   end

   // Lane outputs in parallel mode, eligibility mask in serial mode.
   always_comb begin
      lane_valid_o = '0;
      lane_aer_o   = '0;
      w_elig       = '0;
      for (int k = 0; k < NUM_SLICE; k++) begin
         if (r_head_vld[w_lane2slice[k]] && lane_en_i[k]) begin
            if (!r_mode) begin
               lane_valid_o[k]              = 1'b1;
               lane_aer_o[k*AER_W +: AER_W] = w_head_aer[w_lane2slice[k]];
            end else begin
               w_elig[k] = 1'b1;
            end
         end
      end
   end

   // Round-robin: first eligible lane at or after the pointer.
   always_comb begin
      int unsigned v_idx;
      v_idx   = 0;
      w_grant = r_ptr;
      for (int i = NUM_SLICE - 1; i >= 0; i--) begin
         v_idx = 32'(r_ptr) + 32'(i);
         if (v_idx >= NUM_SLICE) v_idx = v_idx - NUM_SLICE;
         if (w_elig[LANE_W'(v_idx)]) w_grant = LANE_W'(v_idx);
      end
      v_idx = 32'(w_grant) + 1;
      if (v_idx >= NUM_SLICE) v_idx = 0;
      w_ptr_nxt   = LANE_W'(v_idx);
      ser_valid_o = |w_elig;
      ser_aer_o   = ser_valid_o ? w_head_aer[w_lane2slice[w_grant]] : '0;
   end

   always_comb begin
      w_lane_acc = '0;
      w_pop      = '0;
      w_n_acc    = '0;
      for (int k = 0; k < NUM_SLICE; k++) begin
         w_lane_acc[k] = (lane_valid_o[k] & lane_ready_i[k]) |
                         (ser_valid_o & ser_ready_i & (w_grant == LANE_W'(k)));
         w_n_acc       = w_n_acc + CNT_W'(w_lane_acc[k]);
      end
      for (int q = 0; q < NUM_SLICE; q++) begin
         w_pop[q] = w_lane_acc[w_slice2lane[q]];
      end
      w_cnt_sum = {1'b0, r_cnt} + {1'b0, w_n_acc};
   end

   always_comb begin
      w_state_nxt = r_state;
      w_done_nxt  = 1'b0;
      case (r_state)
         S_IDLE: if (start_i) w_state_nxt = S_RUN;
         S_RUN: begin
            if (start_i) begin
               w_state_nxt = S_RUN;
            end else if (r_head_vld == '0) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // Head holds the lowest pending bit; r_pend keeps only the bits behind it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mode     <= 1'b0;
         r_rot      <= '0;
         r_ptr      <= '0;
         r_cnt      <= '0;
         r_head_vld <= '0;
         for (int q = 0; q < NUM_SLICE; q++) begin
            r_pend[q]     <= '0;
            r_head_pos[q] <= '0;
         end
      end else if (start_i) begin
         r_mode <= mode_i;
         r_rot  <= (32'(error_class_i) < NUM_SLICE) ? LANE_W'(error_class_i) : '0;
         r_ptr  <= '0;
         r_cnt  <= '0;
         for (int q = 0; q < NUM_SLICE; q++) begin
            r_head_vld[q] <= |w_slice_in[q];
            r_head_pos[q] <= f_low(w_slice_in[q]);
            r_pend[q]     <= w_slice_in[q] & (w_slice_in[q] - SLICE_DEPTH'(1));
         end
      end else begin
         if (ser_valid_o && ser_ready_i) r_ptr <= w_ptr_nxt;
         r_cnt <= w_cnt_sum[CNT_W] ? '1 : w_cnt_sum[CNT_W-1:0];
         for (int q = 0; q < NUM_SLICE; q++) begin
            if (w_pop[q]) begin
               r_head_vld[q] <= |r_pend[q];
               r_head_pos[q] <= f_low(r_pend[q]);
               r_pend[q]     <= r_pend[q] & (r_pend[q] - SLICE_DEPTH'(1));
            end
         end
      end
   end

   assign busy_o      = (r_state == S_RUN);
   assign done_o      = r_done;
   assign event_cnt_o = r_cnt;

endmodule

// File: tb/tb_aer_encoder_sliced_stream.sv
// Directed and randomized checks of aer_encoder_sliced_stream against a queue-based event model.
module tb_aer_encoder_sliced_stream;

   localparam int NS   = 10;
   localparam int SD   = 20;
   localparam int AW   = 8;
   localparam int CW   = 4;
   localparam int NB   = NS * SD;
   localparam int CNTW = 8;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            start_i = 1'b0;
   logic            mode_i = 1'b0;
   logic [CW-1:0]   error_class_i = '0;
   logic [NB-1:0]   hot_vector_i = '0;
   logic [NS-1:0]   lane_en_i = '1;
   logic [NS-1:0]   lane_ready_i = '1;
   logic [NS-1:0]   lane_valid_o;
   logic [NS*AW-1:0] lane_aer_o;
   logic            ser_ready_i = 1'b1;
   logic            ser_valid_o;
   logic [AW-1:0]   ser_aer_o;
   logic            busy_o;
   logic            done_o;
   logic [CNTW-1:0] event_cnt_o;

   int tests = 0;
   int fails = 0;

   aer_encoder_sliced_stream #(
      .NUM_SLICE(NS), .SLICE_DEPTH(SD), .AER_W(AW), .CLASS_W(CW), .CNT_W(CNTW)
   ) dut (
      .clk(clk), .reset(reset), .start_i(start_i), .mode_i(mode_i),
      .error_class_i(error_class_i), .hot_vector_i(hot_vector_i),
      .lane_en_i(lane_en_i), .lane_ready_i(lane_ready_i),
      .lane_valid_o(lane_valid_o), .lane_aer_o(lane_aer_o),
      .ser_ready_i(ser_ready_i), .ser_valid_o(ser_valid_o), .ser_aer_o(ser_aer_o),
      .busy_o(busy_o), .done_o(done_o), .event_cnt_o(event_cnt_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [AW-1:0] laer(input int k);
      return lane_aer_o[k*AW +: AW];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input logic [NB-1:0] v, input int cls, input logic m);
      start_i       = 1'b1;
      hot_vector_i  = v;
      error_class_i = CW'(cls);
      mode_i        = m;
      tick();
      start_i = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (done_o !== 1'b1 && n < 300) begin
         tick();
         n++;
      end
      chk("wait_done", 64'(done_o), 64'd1);
   endtask

   logic [NB-1:0] v;
   int            qs[NS][$];
   logic [NS-1:0] ev;
   int            rot, ptr, g, q, exp_cnt, guard, cls;
   logic          m;
   bit            pending;

   initial begin
      // reset state
      #3;
      chk("rst_lane_valid", 64'(lane_valid_o), 64'd0);
      chk("rst_lane_aer", 64'(lane_aer_o != '0), 64'd0);
      chk("rst_ser_valid", 64'(ser_valid_o), 64'd0);
      chk("rst_ser_aer", 64'(ser_aer_o), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_done", 64'(done_o), 64'd0);
      chk("rst_cnt", 64'(event_cnt_o), 64'd0);
      #20;
      @(negedge clk);
      reset = 1'b0;
      tick();

      // single event, no rotation
      v = '0; v[37] = 1'b1;
      start_run(v, 0, 1'b0);
      #1;
      chk("t1_valid", 64'(lane_valid_o), 64'h80);
      chk("t1_aer", 64'(laer(7)), 64'd37);
      chk("t1_busy", 64'(busy_o), 64'd1);
      tick(); #1;
      chk("t1_valid_gone", 64'(lane_valid_o), 64'd0);
      chk("t1_done_early", 64'(done_o), 64'd0);
      tick(); #1;
      chk("t1_done", 64'(done_o), 64'd1);
      chk("t1_busy_end", 64'(busy_o), 64'd0);
      chk("t1_cnt", 64'(event_cnt_o), 64'd1);
      tick(); #1;
      chk("t1_done_pulse", 64'(done_o), 64'd0);
      chk("t1_cnt_hold", 64'(event_cnt_o), 64'd1);

      // rotation
      start_run(v, 3, 1'b0);
      #1;
      chk("rot3_valid", 64'(lane_valid_o), 64'h1);
      chk("rot3_aer", 64'(laer(0)), 64'd37);
      wait_done();
      start_run(v, 12, 1'b0);
      #1;
      chk("rot12_valid", 64'(lane_valid_o), 64'h80);
      chk("rot12_aer", 64'(laer(7)), 64'd37);
      wait_done();

      // ordering within a slice
      v = '0; v[2] = 1'b1; v[52] = 1'b1; v[192] = 1'b1;
      start_run(v, 0, 1'b0);
      #1;
      chk("ord_valid", 64'(lane_valid_o), 64'h4);
      chk("ord_aer0", 64'(laer(2)), 64'd2);
      tick(); #1;
      chk("ord_aer1", 64'(laer(2)), 64'd52);
      tick(); #1;
      chk("ord_aer2", 64'(laer(2)), 64'd192);
      wait_done();
      chk("ord_cnt", 64'(event_cnt_o), 64'd3);

      // backpressure holds address and valid
      start_run(v, 0, 1'b0);
      #1;
      chk("bp_aer0", 64'(laer(2)), 64'd2);
      tick();
      lane_ready_i[2] = 1'b0;
      #1;
      chk("bp_valid_a", 64'(lane_valid_o), 64'h4);
      chk("bp_aer_a", 64'(laer(2)), 64'd52);
      tick(); #1;
      chk("bp_valid_b", 64'(lane_valid_o), 64'h4);
      chk("bp_aer_b", 64'(laer(2)), 64'd52);
      lane_ready_i[2] = 1'b1;
      tick(); #1;
      chk("bp_aer_c", 64'(laer(2)), 64'd192);
      wait_done();
      chk("bp_cnt", 64'(event_cnt_o), 64'd3);

      // serial round-robin
      v = '0; v[0] = 1'b1; v[1] = 1'b1; v[11] = 1'b1;
      start_run(v, 0, 1'b1);
      #1;
      chk("ser_valid0", 64'(ser_valid_o), 64'd1);
      chk("ser_aer0", 64'(ser_aer_o), 64'd0);
      chk("ser_lane_quiet", 64'(lane_valid_o), 64'd0);
      tick(); #1;
      chk("ser_aer1", 64'(ser_aer_o), 64'd1);
      tick(); #1;
      chk("ser_aer2", 64'(ser_aer_o), 64'd11);
      tick(); #1;
      chk("ser_idle", 64'(ser_valid_o), 64'd0);
      chk("ser_done_early", 64'(done_o), 64'd0);
      tick(); #1;
      chk("ser_done", 64'(done_o), 64'd1);
      chk("ser_cnt", 64'(event_cnt_o), 64'd3);

      // serial with lane 1 disabled freezes its events
      lane_en_i = 10'h3FD;
      start_run(v, 0, 1'b1);
      #1;
      chk("sdis_aer0", 64'(ser_aer_o), 64'd0);
      tick(); #1;
      chk("sdis_stall", 64'(ser_valid_o), 64'd0);
      repeat (3) tick();
      chk("sdis_busy", 64'(busy_o), 64'd1);
      chk("sdis_nodone", 64'(done_o), 64'd0);
      lane_en_i = '1;
      #1;
      chk("sdis_resume_v", 64'(ser_valid_o), 64'd1);
      chk("sdis_resume_a", 64'(ser_aer_o), 64'd1);
      wait_done();
      chk("sdis_cnt", 64'(event_cnt_o), 64'd3);

      // empty vector
      start_run('0, 0, 1'b0);
      #1;
      chk("empty_busy", 64'(busy_o), 64'd1);
      chk("empty_valid", 64'(lane_valid_o), 64'd0);
      chk("empty_done_early", 64'(done_o), 64'd0);
      tick(); #1;
      chk("empty_done", 64'(done_o), 64'd1);
      chk("empty_busy_end", 64'(busy_o), 64'd0);
      chk("empty_cnt", 64'(event_cnt_o), 64'd0);

      // restart mid-run; coincident accepts are discarded
      v = '0; v[37] = 1'b1; v[100] = 1'b1;
      lane_ready_i = '0;
      start_run(v, 0, 1'b0);
      #1;
      chk("rs_first_valid", 64'(lane_valid_o), 64'h81);
      lane_ready_i = '1;
      v = '0; v[5] = 1'b1;
      start_run(v, 0, 1'b0);
      #1;
      chk("rs_valid", 64'(lane_valid_o), 64'h20);
      chk("rs_aer", 64'(laer(5)), 64'd5);
      chk("rs_nodone", 64'(done_o), 64'd0);
      chk("rs_cnt0", 64'(event_cnt_o), 64'd0);
      wait_done();
      chk("rs_cnt", 64'(event_cnt_o), 64'd1);

      // reset mid-run
      v = '0; v[37] = 1'b1;
      lane_ready_i = '0;
      start_run(v, 0, 1'b0);
      #1;
      chk("mr_valid", 64'(lane_valid_o), 64'h80);
      reset = 1'b1;
      #1;
      chk("mr_lane_valid", 64'(lane_valid_o), 64'd0);
      chk("mr_lane_aer", 64'(lane_aer_o != '0), 64'd0);
      chk("mr_ser_valid", 64'(ser_valid_o), 64'd0);
      chk("mr_busy", 64'(busy_o), 64'd0);
      chk("mr_done", 64'(done_o), 64'd0);
      tick(); tick();
      @(negedge clk);
      reset = 1'b0;
      lane_ready_i = '1;
      tick(); #1;
      chk("mr_post_done", 64'(done_o), 64'd0);
      chk("mr_post_busy", 64'(busy_o), 64'd0);

      // randomized runs against the queue model
      for (int it = 0; it < 40; it++) begin
         int dens;
         dens = $urandom_range(0, 15);
         for (int b = 0; b < NB; b++) v[b] = ($urandom_range(0, 99) < dens);
         cls = $urandom_range(0, 15);
         m   = 1'($urandom_range(0, 1));
         rot = (cls < NS) ? cls : 0;
         ptr = 0;
         exp_cnt = 0;
         for (int s = 0; s < NS; s++) qs[s].delete();
         for (int b = 0; b < NB; b++) if (v[b]) qs[b % NS].push_back(b);
         start_run(v, cls, m);
         guard = 0;
         pending = 1'b0;
         for (int s = 0; s < NS; s++) if (qs[s].size() > 0) pending = 1'b1;
         while (pending && guard < 3000) begin
            for (int k = 0; k < NS; k++) begin
               lane_en_i[k]    = ($urandom_range(0, 9) < 8);
               lane_ready_i[k] = ($urandom_range(0, 9) < 7);
            end
            ser_ready_i = ($urandom_range(0, 9) < 7);
            #1;
            for (int k = 0; k < NS; k++) begin
               q = (k + NS - rot) % NS;
               ev[k] = (qs[q].size() > 0) && lane_en_i[k];
            end
            chk("r_busy", 64'(busy_o), 64'd1);
            if (!m) begin
               chk("r_lane_valid", 64'(lane_valid_o), 64'(ev));
               chk("r_ser_quiet", 64'(ser_valid_o), 64'd0);
               for (int k = 0; k < NS; k++) begin
                  if (ev[k]) begin
                     q = (k + NS - rot) % NS;
                     chk("r_lane_aer", 64'(laer(k)), 64'(qs[q][0]));
                     if (lane_ready_i[k]) begin
                        qs[q].delete(0);
                        exp_cnt++;
                     end
                  end
               end
            end else begin
               chk("r_lane_quiet", 64'(lane_valid_o), 64'd0);
               g = -1;
               for (int i = 0; i < NS; i++) begin
                  int k;
                  k = (ptr + i) % NS;
                  if (g < 0 && ev[k]) g = k;
               end
               chk("r_ser_valid", 64'(ser_valid_o), 64'(g >= 0));
               if (g >= 0) begin
                  q = (g + NS - rot) % NS;
                  chk("r_ser_aer", 64'(ser_aer_o), 64'(qs[q][0]));
                  if (ser_ready_i) begin
                     qs[q].delete(0);
                     exp_cnt++;
                     ptr = (g + 1) % NS;
                  end
               end
            end
            tick();
            guard++;
            pending = 1'b0;
            for (int s = 0; s < NS; s++) if (qs[s].size() > 0) pending = 1'b1;
         end
         tests++;
         assert (guard < 3000) else begin
            fails++;
            $error("FAIL r_timeout: observed %0d cycles expected fewer than 3000", guard);
         end
         chk("r_busy_tail", 64'(busy_o), 64'd1);
         chk("r_done_early", 64'(done_o), 64'd0);
         tick();
         chk("r_done", 64'(done_o), 64'd1);
         chk("r_busy_end", 64'(busy_o), 64'd0);
         chk("r_cnt", 64'(event_cnt_o), 64'(exp_cnt));
      end
      lane_en_i    = '1;
      lane_ready_i = '1;
      ser_ready_i  = 1'b1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
